switch_in_ctrl: RTL

Parametrised switch-input peripheral for the minimal SOPC. Synchronises and debounces `WIDTH` raw switch lines and drives the debounced vector onto the core's `switch_on` input. Exposes state, sticky edge-capture and interrupt-mask registers on a simple word-addressed bus, and raises a level interrupt on unmasked captured edges. Replaces the bench-driven constant `switch_on` vector with clean, cycle-accurate hardware.

---
 rtl/switch_in_pkg.sv | 14 +
 rtl/switch_debounce_chan.sv | 48 ++++
 rtl/switch_in_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/switch_in_pkg.sv
// switch_in_pkg: shared constants for the switch-input peripheral.
// Holds the bus register map and the edge-capture mode encodings.
package switch_in_pkg;

    localparam logic [1:0] SW_ADDR_STATE = 2'd0;
    localparam logic [1:0] SW_ADDR_EDGE  = 2'd1;
    localparam logic [1:0] SW_ADDR_IMASK = 2'd2;
    localparam logic [1:0] SW_ADDR_RSVD  = 2'd3;

    localparam int SW_EDGE_BOTH = 0;
    localparam int SW_EDGE_RISE = 1;
    localparam int SW_EDGE_FALL = 2;

endpackage

// File: rtl/switch_debounce_chan.sv
// switch_debounce_chan: one switch channel -- synchroniser chain,
// stability counter and the debounced output flop.
// Ports: clk, rst (async, active-low), i_raw (async pin), o_stable.
module switch_debounce_chan #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_stable;
    logic                   w_s;
    logic                   w_diff;
    logic                   w_accept;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_diff   = w_s ^ r_stable;
    // Accept on the edge where the count would reach DEBOUNCE_CYCLES.
    assign w_accept = w_diff && (r_cnt == CNT_LAST);
    assign o_stable = r_stable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            if (!w_diff || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_accept) begin
                r_stable <= w_s;
            end
        end
    end

endmodule

// File: rtl/switch_in_ctrl.sv
// switch_in_ctrl: debounced switch inputs with STATE / EDGE (W1C) /
// IMASK registers on a word bus and a registered level interrupt.
// Ports: clk, rst (async, active-low), sw_raw, sw_stable, ce, we,
// addr, wdata, rdata, int_o. Macro SWITCH_EDGE_IRQ_EN builds the
// EDGE/IMASK/interrupt logic; without it those read 0 and int_o is 0.
module switch_in_ctrl
    import switch_in_pkg::*;
#(
    parameter int WIDTH           = 12,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    input  logic             ce,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             int_o
);

    logic [31:0] w_state32;
    logic [31:0] w_edge32;
    logic [31:0] w_imask32;
    logic        w_rd;
    logic        w_unused;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        switch_debounce_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (sw_raw[g]),
            .o_stable(sw_stable[g])
        );
    end

    assign w_rd     = ce && !we;
    assign w_unused = ^wdata;

`ifdef SWITCH_EDGE_IRQ_EN
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_imask;
    logic             r_int;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_w1c;
    logic             w_wr_mask;

    assign w_rise    = sw_stable & ~r_prev;
    assign w_fall    = ~sw_stable & r_prev;
    assign w_wr_mask = ce && we && (addr == SW_ADDR_IMASK);

    always_comb begin
        w_set = w_rise | w_fall;
        if (EDGE_MODE == SW_EDGE_RISE) begin
            w_set = w_rise;
        end else if (EDGE_MODE == SW_EDGE_FALL) begin
            w_set = w_fall;
        end
    end

    always_comb begin
        w_w1c = '0;
        if (ce && we && (addr == SW_ADDR_EDGE)) begin
            w_w1c = wdata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev  <= '0;
            r_edge  <= '0;
            r_imask <= '0;
            r_int   <= 1'b0;
        end else begin
            r_prev <= sw_stable;
            // Set is OR-ed in after the clear, so a new edge wins.
            r_edge <= (r_edge & ~w_w1c) | w_set;
            if (w_wr_mask) begin
                r_imask <= wdata[WIDTH-1:0];
            end
            r_int <= |(r_edge & r_imask);
        end
    end

    always_comb begin
        w_edge32               = '0;
        w_edge32[WIDTH-1:0]    = r_edge;
        w_imask32              = '0;
        w_imask32[WIDTH-1:0]   = r_imask;
    end

    assign int_o = r_int;
`else
    assign w_edge32  = '0;
    assign w_imask32 = '0;
    assign int_o     = 1'b0;
`endif

    always_comb begin
        w_state32            = '0;
        w_state32[WIDTH-1:0] = sw_stable;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (w_rd) begin
            case (addr)
                SW_ADDR_STATE: rdata <= w_state32;
                SW_ADDR_EDGE:  rdata <= w_edge32;
                SW_ADDR_IMASK: rdata <= w_imask32;
                default:       rdata <= '0;
            endcase
        end
    end

endmodule
